// File: rtl/vga_frame_arbiter_pkg.sv
// Shared definitions for the VGA frame-RAM arbiter: pixel geometry, the
// display timing constants shared with the VGA controller, and the
// per-cycle RAM slot type.
package vga_frame_arbiter_pkg;

  localparam int PIX_ADDR_W   = 19;      // 640x480 pixels fit in 19 bits
  localparam int PIX_COLOR_W  = 3;       // RGB 1:1:1
  localparam int FRAME_PIXELS = 307200;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  // Display fetches always win; queued writes take any otherwise free cycle.
  function automatic slot_e pick_slot(input logic rd_req, input logic fifo_empty);
    if (rd_req) return SLOT_READ;
    if (!fifo_empty) return SLOT_WRITE;
    return SLOT_IDLE;
  endfunction

endpackage

// File: rtl/vga_write_fifo.sv
// Synchronous write-buffer FIFO with occupancy output. DEPTH must be a
// power of two so the pointers wrap naturally.
module vga_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: data only, no reset needed since level gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; simultaneous push and pop leave the level alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/vga_frame_arbiter.sv
// Arbitrates one single-port frame RAM between display fetches (fixed
// 3-cycle latency, absolute priority) and buffered draw-engine writes.
// Optional feature macro: VGA_DOUBLE_BUFFER_EN enables two frame banks
// with a display-bank swap taken at the start of vertical blanking.
module vga_frame_arbiter
  import vga_frame_arbiter_pkg::*;
#(
  parameter int ADDR_W     = PIX_ADDR_W,
  parameter int COLOR_W    = PIX_COLOR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vgaReq,
  input  logic [ADDR_W-1:0]           vgaAddr,
  output logic [COLOR_W-1:0]          vgaData,
  output logic                        vgaValid,
  input  logic                        wrValid,
  input  logic [ADDR_W-1:0]           wrAddr,
  input  logic [COLOR_W-1:0]          wrData,
  output logic                        wrReady,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
  input  logic                        vBlankStart,
  input  logic                        swapReq,
  output logic                        swapDone,
  output logic [ADDR_W:0]             memAddr,
  output logic                        memWe,
  output logic [COLOR_W-1:0]          memWrData,
  input  logic [COLOR_W-1:0]          memRdData
);

  // Queue entry layout: {bank, addr, data}; the bank is frozen at push time.
  localparam int ENT_W = 1 + ADDR_W + COLOR_W;

  slot_e              slot;
  logic               push, pop, full, empty;
  logic [ENT_W-1:0]   head, wr_ent;
  logic               draw_bank;

  logic               disp_bank_q, disp_bank_d;
  logic               swap_pend_q, swap_pend_d;
  logic               swap_done_q, swap_done_d;
  logic [ADDR_W:0]    mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [COLOR_W-1:0] mem_wd_q, mem_wd_d;
  logic               vld_p0_q, vld_p1_q, vga_valid_q;
  logic [COLOR_W-1:0] vga_data_q;

  vga_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_ent),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifoLevel)
  );

`ifdef VGA_DOUBLE_BUFFER_EN
  assign draw_bank = ~disp_bank_q;

  // Swap bookkeeping: a request waits for vblank; repeat requests merge.
  always_comb begin
    disp_bank_d = disp_bank_q;
    swap_pend_d = swap_pend_q;
    swap_done_d = 1'b0;
    if (vBlankStart && (swap_pend_q || swapReq)) begin
      disp_bank_d = ~disp_bank_q;
      swap_pend_d = 1'b0;
      swap_done_d = 1'b1;
    end else if (swapReq) begin
      swap_pend_d = 1'b1;
    end
  end
`else
  logic unused_swap_inputs;
  assign unused_swap_inputs = ^{swapReq, vBlankStart};
  assign draw_bank   = 1'b0;
  assign disp_bank_d = 1'b0;
  assign swap_pend_d = 1'b0;
  assign swap_done_d = 1'b0;
`endif

  assign wr_ent  = {draw_bank, wrAddr, wrData};
  assign wrReady = !full;
  assign push    = wrValid && !full;
  assign pop     = (slot == SLOT_WRITE);

  // Per-cycle RAM grant; idle cycles keep address and write data steady.
  always_comb begin
    slot       = pick_slot(vgaReq, empty);
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    mem_wd_d   = mem_wd_q;
    case (slot)
      SLOT_READ:  mem_addr_d = {disp_bank_q, vgaAddr};
      SLOT_WRITE: begin
        mem_addr_d = head[ENT_W-1 -: ADDR_W+1];
        mem_wd_d   = head[COLOR_W-1:0];
        mem_we_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered RAM interface, read-valid pipeline and bank state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wd_q    <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_data_q  <= '0;
      disp_bank_q <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      // p0: address presented to the RAM
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wd_q    <= mem_wd_d;
      vld_p0_q    <= (slot == SLOT_READ);
      // p1: RAM output register holds the pixel
      vld_p1_q    <= vld_p0_q;
      // p2: pixel handed to the display
      vga_valid_q <= vld_p1_q;
      if (vld_p1_q) vga_data_q <= memRdData;
      disp_bank_q <= disp_bank_d;
      swap_pend_q <= swap_pend_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign memAddr   = mem_addr_q;
  assign memWe     = mem_we_q;
  assign memWrData = mem_wd_q;
  assign vgaData   = vga_data_q;
  assign vgaValid  = vga_valid_q;
  assign swapDone  = swap_done_q;

endmodule
